// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - Control-unit to datapath signal bundle
//
// Groups everything the control unit exchanges with the datapath.
// master (control unit): receives IR, CON_FF and stop, and drives every strobe
//                        plus opcode and Run.
// slave  (datapath)    : the mirror image.
// Signals:
//   IR[31:0]  instruction register; the opcode is IR[31:27]
//   CON_FF    branch-condition flag
//   stop      halt request, sampled when the next fetch would start
//   register select/encode : Gra Grb Grc Rin Rout BAout
//   fetch/memory path      : PCin PCout IncPC IRin MARin MDRin MDRout
//   ALU/result             : Yin Zin Zhighout Zlowout HIin LOin HIout LOout Cout
//   I/O, condition, memory : InPortout OutPortin CONin Read Write
//   opcode[4:0]            : ALU operation, valid only in execute states
//   Run                    : low only while halted
interface control_unit_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        stop;

    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout;
    logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout;
    logic InPortout, OutPortin, CONin, Read, Write;
    logic [4:0] opcode;
    logic       Run;

    modport master (
        input  IR, CON_FF, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout,
        output Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout,
        output InPortout, OutPortin, CONin, Read, Write,
        output opcode, Run
    );

    modport slave (
        output IR, CON_FF, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout,
        input  Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout,
        input  InPortout, OutPortin, CONin, Read, Write,
        input  opcode, Run
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control unit sequencing fetch and execute steps
//
// Ports:
//   clock  rising-edge clock
//   clear  asynchronous active-high reset into RESET
//   cu     control_unit_if.master: IR/CON_FF/stop in, all strobes, opcode, Run out
// Parameter:
//   MEM_WAIT  extra cycles (0..3) that a memory read (fetch T1, ld T6) is held
//
// Every output is decoded from the current state only, except that the branch
// target load in br T6 is qualified by CON_FF.
module control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic clock,
    input  logic clear,
    control_unit_if.master cu
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // Instruction classes; several opcodes share an identical step sequence.
    typedef enum logic [3:0] {
        K_LD, K_LDI, K_ST, K_ALU, K_IMM, K_MULDIV, K_NEGNOT, K_BR,
        K_JR, K_JAL, K_IN, K_OUT, K_MFHI, K_MFLO, K_NOP, K_HALT
    } kind_t;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

    state_t     state, next_state;
    logic [1:0] wait_cnt, wait_next;
    logic [4:0] ir_op;
    kind_t      kind;
    logic       wait_done;
    state_t     fetch_target;

    assign ir_op     = cu.IR[31:27];
    assign wait_done = (wait_cnt == WAIT_LAST);
    // Every path back to fetch honours a pending halt request instead.
    assign fetch_target = cu.stop ? S_HALT : S_T0;

    always_comb begin
        kind = K_NOP;                      // undefined opcodes run as nop
        if (ir_op == 5'd0)                          kind = K_LD;
        else if (ir_op == 5'd1)                     kind = K_LDI;
        else if (ir_op == 5'd2)                     kind = K_ST;
        else if (ir_op <= 5'd10)                    kind = K_ALU;
        else if (ir_op <= 5'd13)                    kind = K_IMM;
        else if (ir_op <= 5'd15)                    kind = K_MULDIV;
        else if (ir_op <= 5'd17)                    kind = K_NEGNOT;
        else if (ir_op == 5'd18)                    kind = K_BR;
        else if (ir_op == 5'd19)                    kind = K_JR;
        else if (ir_op == 5'd20)                    kind = K_JAL;
        else if (ir_op == 5'd21)                    kind = K_IN;
        else if (ir_op == 5'd22)                    kind = K_OUT;
        else if (ir_op == 5'd23)                    kind = K_MFHI;
        else if (ir_op == 5'd24)                    kind = K_MFLO;
        else if (ir_op == 5'd26)                    kind = K_HALT;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        next_state   = state;
        wait_next    = '0;
        cu.Gra       = 1'b0;  cu.Grb      = 1'b0;  cu.Grc      = 1'b0;
        cu.Rin       = 1'b0;  cu.Rout     = 1'b0;  cu.BAout    = 1'b0;
        cu.PCin      = 1'b0;  cu.PCout    = 1'b0;  cu.IncPC    = 1'b0;
        cu.IRin      = 1'b0;  cu.MARin    = 1'b0;  cu.MDRin    = 1'b0;
        cu.MDRout    = 1'b0;  cu.Yin      = 1'b0;  cu.Zin      = 1'b0;
        cu.Zhighout  = 1'b0;  cu.Zlowout  = 1'b0;  cu.HIin     = 1'b0;
        cu.LOin      = 1'b0;  cu.HIout    = 1'b0;  cu.LOout    = 1'b0;
        cu.Cout      = 1'b0;  cu.InPortout = 1'b0; cu.OutPortin = 1'b0;
        cu.CONin     = 1'b0;  cu.Read     = 1'b0;  cu.Write    = 1'b0;
        cu.opcode    = 5'b00000;
        cu.Run       = 1'b1;

        unique case (state)
            S_RESET: next_state = fetch_target;
            S_T0: begin
                cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                cu.Zlowout = 1'b1; cu.Read = 1'b1; cu.MDRin = 1'b1;
                // Hold the read until memory has had MEM_WAIT extra cycles;
                // the incremented PC is committed only once, on the last one.
                if (wait_done) begin
                    cu.PCin    = 1'b1;
                    next_state = S_T2;
                end else begin
                    wait_next = wait_cnt + 2'd1;
                end
            end
            S_T2: begin
                cu.MDRout = 1'b1; cu.IRin = 1'b1;
                next_state = S_T3;
            end
            S_HALT: cu.Run = 1'b0;
            default: begin
                // Execute states T3..T7. Unless a step below says otherwise,
                // the current step is the last one of the instruction.
                cu.opcode  = ir_op;
                next_state = fetch_target;
                unique case (kind)
                    K_LD, K_LDI, K_ST: begin
                        if (state == S_T3) begin
                            cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1;
                            next_state = S_T4;
                        end else if (state == S_T4) begin
                            cu.Cout = 1'b1; cu.Zin = 1'b1;
                            next_state = S_T5;
                        end else if (state == S_T5) begin
                            cu.Zlowout = 1'b1;
                            if (kind == K_LDI) begin
                                cu.Gra = 1'b1; cu.Rin = 1'b1;
                            end else begin
                                cu.MARin   = 1'b1;
                                next_state = S_T6;
                            end
                        end else if (state == S_T6) begin
                            if (kind == K_LD) begin
                                cu.Read = 1'b1; cu.MDRin = 1'b1;
                                if (wait_done) begin
                                    next_state = S_T7;
                                end else begin
                                    next_state = S_T6;
                                    wait_next  = wait_cnt + 2'd1;
                                end
                            end else begin
                                cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1;
                                next_state = S_T7;
                            end
                        end else begin
                            if (kind == K_LD) begin
                                cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                            end else begin
                                cu.Write = 1'b1;
                            end
                        end
                    end
                    K_ALU, K_IMM: begin
                        if (state == S_T3) begin
                            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
                            next_state = S_T4;
                        end else if (state == S_T4) begin
                            cu.Zin = 1'b1;
                            if (kind == K_ALU) begin
                                cu.Grc = 1'b1; cu.Rout = 1'b1;
                            end else begin
                                cu.Cout = 1'b1;
                            end
                            next_state = S_T5;
                        end else begin
                            cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                        end
                    end
                    K_MULDIV: begin
                        if (state == S_T3) begin
                            cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
                            next_state = S_T4;
                        end else if (state == S_T4) begin
                            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1;
                            next_state = S_T5;
                        end else if (state == S_T5) begin
                            cu.Zlowout = 1'b1; cu.LOin = 1'b1;
                            next_state = S_T6;
                        end else begin
                            cu.Zhighout = 1'b1; cu.HIin = 1'b1;
                        end
                    end
                    K_NEGNOT: begin
                        if (state == S_T3) begin
                            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1;
                            next_state = S_T4;
                        end else begin
                            cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                        end
                    end
                    K_BR: begin
                        if (state == S_T3) begin
                            cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1;
                            next_state = S_T4;
                        end else if (state == S_T4) begin
                            cu.PCout = 1'b1; cu.Yin = 1'b1;
                            next_state = S_T5;
                        end else if (state == S_T5) begin
                            cu.Cout = 1'b1; cu.Zin = 1'b1;
                            next_state = S_T6;
                        end else begin
                            // Branch target is taken only when the condition held.
                            cu.Zlowout = cu.CON_FF;
                            cu.PCin    = cu.CON_FF;
                        end
                    end
                    K_JR: begin
                        cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1;
                    end
                    K_JAL: begin
                        if (state == S_T3) begin
                            cu.PCout = 1'b1; cu.Grb = 1'b1; cu.Rin = 1'b1;
                            next_state = S_T4;
                        end else begin
                            cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1;
                        end
                    end
                    K_IN: begin
                        cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                    end
                    K_OUT: begin
                        cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortin = 1'b1;
                    end
                    K_MFHI: begin
                        cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                    end
                    K_MFLO: begin
                        cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                    end
                    K_HALT: next_state = S_HALT;
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - Self-checking bench for control_unit
module tb_control_unit;

    localparam logic [26:0] GRA = 27'h1 << 26, GRB = 27'h1 << 25, GRC = 27'h1 << 24,
        RIN = 27'h1 << 23, ROUT = 27'h1 << 22, BAOUT = 27'h1 << 21, PCIN = 27'h1 << 20,
        PCOUT = 27'h1 << 19, INCPC = 27'h1 << 18, IRIN = 27'h1 << 17, MARIN = 27'h1 << 16,
        MDRIN = 27'h1 << 15, MDROUT = 27'h1 << 14, YIN = 27'h1 << 13, ZIN = 27'h1 << 12,
        ZHIGHOUT = 27'h1 << 11, ZLOWOUT = 27'h1 << 10, HIIN = 27'h1 << 9, LOIN = 27'h1 << 8,
        HIOUT = 27'h1 << 7, LOOUT = 27'h1 << 6, COUT = 27'h1 << 5, INPORTOUT = 27'h1 << 4,
        OUTPORTIN = 27'h1 << 3, CONIN = 27'h1 << 2, READ = 27'h1 << 1, WRITE = 27'h1;
    localparam logic [26:0] OUTS = ROUT | BAOUT | PCOUT | MDROUT | ZHIGHOUT | ZLOWOUT |
                                   HIOUT | LOOUT | COUT | INPORTOUT;
    localparam logic [26:0] T0_MASK = PCOUT | MARIN | INCPC | ZIN;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;

    always #5 clock = ~clock;

    control_unit_if b0();
    control_unit_if b2();

    assign b0.IR = ir;  assign b0.CON_FF = con_ff;  assign b0.stop = stop;
    assign b2.IR = ir;  assign b2.CON_FF = con_ff;  assign b2.stop = stop;

    control_unit #(.MEM_WAIT(0)) u0 (.clock(clock), .clear(clear), .cu(b0.master));
    control_unit #(.MEM_WAIT(2)) u2 (.clock(clock), .clear(clear), .cu(b2.master));

    logic [26:0] m0, m2;
    assign m0 = {b0.Gra, b0.Grb, b0.Grc, b0.Rin, b0.Rout, b0.BAout, b0.PCin, b0.PCout,
                 b0.IncPC, b0.IRin, b0.MARin, b0.MDRin, b0.MDRout, b0.Yin, b0.Zin,
                 b0.Zhighout, b0.Zlowout, b0.HIin, b0.LOin, b0.HIout, b0.LOout, b0.Cout,
                 b0.InPortout, b0.OutPortin, b0.CONin, b0.Read, b0.Write};
    assign m2 = {b2.Gra, b2.Grb, b2.Grc, b2.Rin, b2.Rout, b2.BAout, b2.PCin, b2.PCout,
                 b2.IncPC, b2.IRin, b2.MARin, b2.MDRin, b2.MDRout, b2.Yin, b2.Zin,
                 b2.Zhighout, b2.Zlowout, b2.HIin, b2.LOin, b2.HIout, b2.LOout, b2.Cout,
                 b2.InPortout, b2.OutPortin, b2.CONin, b2.Read, b2.Write};

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [26:0] exp_m[$];
    bit          exp_x[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] mask_of(input int sel);
        return (sel == 0) ? m0 : m2;
    endfunction

    function automatic logic [4:0] op_of(input int sel);
        return (sel == 0) ? b0.opcode : b2.opcode;
    endfunction

    function automatic logic run_of(input int sel);
        return (sel == 0) ? b0.Run : b2.Run;
    endfunction

    task automatic check_cycle(input int sel, input string tag, input logic [26:0] em,
                               input logic [4:0] eop, input logic erun);
        logic [26:0] m;
        m = mask_of(sel);
        chk({tag, " strobes"}, 32'(m), 32'(em));
        chk({tag, " opcode"}, 32'(op_of(sel)), 32'(eop));
        chk({tag, " Run"}, 32'(run_of(sel)), 32'(erun));
        chk({tag, " read_write"}, 32'(m[1] & m[0]), 32'd0);
        chk({tag, " one_bus_driver"}, 32'($countones(m & OUTS) <= 1), 32'd1);
    endtask

    task automatic push(input logic [26:0] m, input bit x);
        exp_m.push_back(m);
        exp_x.push_back(x);
    endtask

    // Reference: the list of strobe sets an instruction produces, cycle by cycle.
    task automatic build(input logic [4:0] op, input int mw, input bit con);
        int o;
        o = int'(op);
        exp_m.delete();
        exp_x.delete();
        push(T0_MASK, 0);
        for (int i = 0; i <= mw; i++) push(ZLOWOUT | READ | MDRIN | ((i == mw) ? PCIN : 27'h0), 0);
        push(MDROUT | IRIN, 0);
        if (o <= 2) begin
            push(GRB | BAOUT | YIN, 1);
            push(COUT | ZIN, 1);
            if (o == 1) push(ZLOWOUT | GRA | RIN, 1);
            else push(ZLOWOUT | MARIN, 1);
            if (o == 0) begin
                for (int i = 0; i <= mw; i++) push(READ | MDRIN, 1);
                push(MDROUT | GRA | RIN, 1);
            end else if (o == 2) begin
                push(GRA | ROUT | MDRIN, 1);
                push(WRITE, 1);
            end
        end else if (o <= 13) begin
            push(GRB | ROUT | YIN, 1);
            push((o <= 10) ? (GRC | ROUT | ZIN) : (COUT | ZIN), 1);
            push(ZLOWOUT | GRA | RIN, 1);
        end else if (o <= 15) begin
            push(GRA | ROUT | YIN, 1);
            push(GRB | ROUT | ZIN, 1);
            push(ZLOWOUT | LOIN, 1);
            push(ZHIGHOUT | HIIN, 1);
        end else if (o <= 17) begin
            push(GRB | ROUT | ZIN, 1);
            push(ZLOWOUT | GRA | RIN, 1);
        end else if (o == 18) begin
            push(GRA | ROUT | CONIN, 1);
            push(PCOUT | YIN, 1);
            push(COUT | ZIN, 1);
            push(con ? (ZLOWOUT | PCIN) : 27'h0, 1);
        end else if (o == 19) push(GRA | ROUT | PCIN, 1);
        else if (o == 20) begin
            push(PCOUT | GRB | RIN, 1);
            push(GRA | ROUT | PCIN, 1);
        end
        else if (o == 21) push(INPORTOUT | GRA | RIN, 1);
        else if (o == 22) push(GRA | ROUT | OUTPORTIN, 1);
        else if (o == 23) push(HIOUT | GRA | RIN, 1);
        else if (o == 24) push(LOOUT | GRA | RIN, 1);
        else push(27'h0, 1);                 // nop, halt T3, undefined opcodes
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, release, then run one instruction and check what follows it.
    task automatic run_instr(input int sel, input logic [4:0] op, input bit con,
                             input bit stop_end);
        string tag;
        tag = $sformatf("dut%0d op%0d", (sel == 0) ? 0 : 2, op);
        ir     = {op, 27'($urandom)};
        con_ff = con;
        stop   = 1'b0;
        clear  = 1'b1;
        tick();
        check_cycle(sel, {tag, " reset"}, 27'h0, 5'd0, 1'b1);
        @(negedge clock);
        clear = 1'b0;
        build(op, (sel == 0) ? 0 : 2, con);
        foreach (exp_m[i]) begin
            tick();
            check_cycle(sel, $sformatf("%s step%0d", tag, i), exp_m[i],
                        exp_x[i] ? op : 5'd0, 1'b1);
        end
        if (op == 5'd26) begin
            for (int c = 0; c < 20; c++) begin
                tick();
                check_cycle(sel, {tag, " halted"}, 27'h0, 5'd0, 1'b0);
            end
        end else begin
            stop = stop_end;
            tick();
            if (stop_end) check_cycle(sel, {tag, " stop_halt"}, 27'h0, 5'd0, 1'b0);
            else          check_cycle(sel, {tag, " next_t0"}, T0_MASK, 5'd0, 1'b1);
            stop = 1'b0;
        end
    endtask

    int ops[32];

    initial begin
        // add on the zero-wait unit, then ld with a stretched memory read
        run_instr(0, 5'd3, 1'b0, 1'b0);
        run_instr(1, 5'd0, 1'b0, 1'b0);
        // branch not taken, then taken
        run_instr(0, 5'd18, 1'b0, 1'b0);
        run_instr(0, 5'd18, 1'b1, 1'b0);
        run_instr(1, 5'd18, 1'b1, 1'b0);

        // halt, then recovery through clear
        run_instr(0, 5'd26, 1'b0, 1'b0);
        clear = 1'b1;
        #2;
        check_cycle(0, "halt clear", 27'h0, 5'd0, 1'b1);
        @(negedge clock);
        clear = 1'b0;
        tick();
        check_cycle(0, "halt release", T0_MASK, 5'd0, 1'b1);

        // stop requested at the end of an instruction, and at reset release
        run_instr(0, 5'd25, 1'b0, 1'b1);
        clear = 1'b1;
        stop  = 1'b1;
        tick();
        @(negedge clock);
        clear = 1'b0;
        tick();
        check_cycle(0, "stop_at_release", 27'h0, 5'd0, 1'b0);
        stop = 1'b0;

        // clear during st T6 must drop strobes at once and never produce Write
        ir    = {5'd2, 27'h0};
        clear = 1'b1;
        tick();
        @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check_cycle(0, "st t6", GRA | ROUT | MDRIN, 5'd2, 1'b1);
        #2;
        clear = 1'b1;
        #1;
        check_cycle(0, "st async clear", 27'h0, 5'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_cycle(0, "st held clear", 27'h0, 5'd0, 1'b1);
        end

        // every opcode in shuffled order on both units with random CON_FF
        for (int i = 0; i < 32; i++) ops[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = ops[i]; ops[i] = ops[j]; ops[j] = t;
        end
        for (int i = 0; i < 32; i++) begin
            run_instr(0, 5'(ops[i]), 1'($urandom), 1'b0);
            run_instr(1, 5'(ops[i]), 1'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
